// File: rtl/bcd_counter.sv
// Single-digit BCD (decade) counter with a combinational rollover carry.
// Cascade digits by feeding one digit's carry into the next digit's enable.
module bcd_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [3:0] count,
  output logic       carry
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Any value at or above 9 returns to 0, so the unreachable codes 10..15 self-clear.
  always_comb begin
    count_d = count_q;
    if (enable) begin
      if (count_q >= 4'd9) begin
        count_d = '0;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign carry = enable & (count_q == 4'd9);

endmodule

// File: tb/tb_bcd_counter.sv
// Directed self-checking bench for bcd_counter.
module tb_bcd_counter;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] count;
  logic       carry;

  int unsigned n_cmp;
  int unsigned n_bad;

  bcd_counter dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .count  (count),
    .carry  (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    enable = 1'b0;

    // Reset held for several cycles.
    repeat (3) step();
    check("reset_count", {4'd0, count}, 8'd0);
    check("reset_carry", {7'd0, carry}, 8'd0);

    // Hold while disabled.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_disabled", {4'd0, count}, 8'd0);
    end

    // Full decade sequence with carry observed before each edge.
    enable = 1'b1;
    #1;
    for (int i = 1; i <= 10; i++) begin
      check("seq_carry", {7'd0, carry}, ((i - 1) == 9) ? 8'd1 : 8'd0);
      step();
      check("seq_count", {4'd0, count}, 8'(i % 10));
    end

    // Carry behaviour around 9 with an asynchronous reset between edges.
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", {4'd0, count}, 8'd0);
    rst = 1'b1;
    repeat (9) step();
    check("carry_cnt9", {4'd0, count}, 8'd9);
    check("carry_high", {7'd0, carry}, 8'd1);
    enable = 1'b0;
    #1;
    check("carry_drop", {7'd0, carry}, 8'd0);
    repeat (2) step();
    check("hold_at_9", {4'd0, count}, 8'd9);
    enable = 1'b1;
    #1;
    check("carry_again", {7'd0, carry}, 8'd1);
    step();
    check("wrap_count", {4'd0, count}, 8'd0);
    check("wrap_carry", {7'd0, carry}, 8'd0);

    // Reset in the middle of counting.
    repeat (5) step();
    check("mid_cnt5", {4'd0, count}, 8'd5);
    #2;
    rst = 1'b0;
    #1;
    check("mid_reset", {4'd0, count}, 8'd0);
    step();
    check("mid_reset_held", {4'd0, count}, 8'd0);
    rst = 1'b1;
    step();
    check("mid_resume", {4'd0, count}, 8'd1);

    // Long run from 0, then hold.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      check("long_run", {4'd0, count}, 8'(i % 10));
    end
    enable = 1'b0;
    repeat (4) step();
    check("long_hold", {4'd0, count}, 8'd0);
    check("long_hold_carry", {7'd0, carry}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
Single-digit synchronous BCD (decade) counter: counts 0..9 when enabled, wraps to 0, and flags the 9->0 rollover with a carry. It is the basic digit cell for multi-digit decimal counters/displays: cascade by feeding one digit's carry into the next digit's enable.

Parameters:
None. The counter is fixed at 4-bit BCD, modulus 10.

Ports:
clk     input   1  system clock; all state updates on rising edge
rst     input   1  asynchronous, active-low reset (rst=0 resets); one clock; release synchronised externally
enable  input   1  count enable, sampled on rising clk
count   output  4  current BCD digit, 0..9, registered
carry   output  1  rollover flag, combinational: enable AND (count==9)

Behaviour:
- Reset: rst=0 forces count=4'd0 immediately, without waiting for clk. Held at 0 for as long as rst=0, regardless of enable. carry=0 during reset, since count=0.
- Normal (rst=1), on each rising clk:
  - enable=1 and count<9: count <= count+1.
  - enable=1 and count==9: count <= 0 (decade wrap).
  - enable=0: count holds its value.
- Latency: count changes on the first rising edge at which enable=1 is sampled. There is no pipeline.
- carry = enable & (count==4'd9). It is purely combinational, with no register.
  - It is high for the whole cycle in which the next edge performs 9->0.
  - It drops immediately if enable falls.
  - It is 0 at every count other than 9.
- Illegal states 10..15 (unreachable in normal operation): on the next enabled edge, count <= 0. carry stays 0 in these states.
- Reset mid-count: asserting rst at any count value (e.g. 5) yields count=0 with no clock edge required. Counting resumes from 0 on the first enabled edge after rst returns to 1.
- Enable toggling: no effect other than gating increments. The count value is preserved across any number of disabled cycles.
- Output count is driven directly from the state register, so it is glitch-free.

Test Plan:
- Reset: hold rst=0 for 3+ clk cycles with enable=0, then sample -> count=0 and carry=0. Also assert rst=0 between clock edges -> count goes to 0 before the next posedge.
- Hold when disabled: release rst with enable=0, run 5 edges -> count stays 0.
- Count sequence: enable=1 from count=0, sample 1 ns after each posedge -> 0,1,2,...,9, then 0 after the 10th edge.
- Carry: reset, then enable for 9 edges -> count=9 and carry=1. Next edge -> count=0 and carry=0. With count=9, drop enable -> carry=0 immediately and count holds at 9.
- Reset mid-operation: count 5 edges (count=5), assert rst=0 -> count=0. Release rst -> count increments from 0.
- Long run and hold: 30 enabled edges from 0 -> count follows i mod 10 and ends at 0. Then set enable=0 for 4 edges -> count stays 0.
